// File: rtl/rf_2p_be_clr.sv
// Two-port register file: port A read, port B byte-masked write, with optional
// write-to-read forwarding, optional output register and a sequential clear engine.
module rf_2p_be_clr #(
    parameter int unsigned Word_Width = 32,
    parameter int unsigned Addr_Width = 8,
    parameter int unsigned Out_Reg    = 0,
    parameter int unsigned Fwd_En     = 1,
    localparam int unsigned Byte_Width = Word_Width >> 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cena_i,
    input  logic [Addr_Width-1:0] addra_i,
    output logic [Word_Width-1:0] dataa_o,
    output logic                  vlda_o,
    input  logic                  cenb_i,
    input  logic [Byte_Width-1:0] wenb_i,
    input  logic [Addr_Width-1:0] addrb_i,
    input  logic [Word_Width-1:0] datab_i,
    input  logic                  clr_i,
    output logic                  busy_o
);

    localparam int unsigned Depth = 1 << Addr_Width;

    typedef enum logic {StIdle, StClear} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [Addr_Width-1:0] r_cnt;
    logic [Addr_Width-1:0] w_cnt_nxt;

    logic [Word_Width-1:0] r_mem [Depth];

    logic                  w_busy;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_clr_we;
    logic [Word_Width-1:0] w_rd_word;

    logic [Word_Width-1:0] r_data1;
    logic                  r_vld1;

    assign w_busy   = (r_state == StClear);
    assign w_wr_en  = !cenb_i && !w_busy && (wenb_i != {Byte_Width{1'b1}});
    assign w_rd_en  = !cena_i && !w_busy;
    // A reset landing mid-clear must not zero the word at the current count.
    assign w_clr_we = w_busy && !rst;
    assign busy_o   = w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (clr_i) begin
                    w_state_nxt = StClear;
                    w_cnt_nxt   = '0;
                end
            end
            StClear: begin
                w_cnt_nxt = r_cnt + Addr_Width'(1);
                if (r_cnt == {Addr_Width{1'b1}}) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int j = 0; j < Byte_Width; j++) begin
                if (!wenb_i[j]) begin
                    r_mem[addrb_i][8*j +: 8] <= datab_i[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_word = r_mem[addra_i];
        if ((Fwd_En != 0) && w_wr_en && (addra_i == addrb_i)) begin
            for (int j = 0; j < Byte_Width; j++) begin
                if (!wenb_i[j]) begin
                    w_rd_word[8*j +: 8] = datab_i[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data1 <= '0;
            r_vld1  <= 1'b0;
        end else begin
            r_vld1 <= w_rd_en;
            if (w_rd_en) begin
                r_data1 <= w_rd_word;
            end
        end
    end

    generate
        if (Out_Reg != 0) begin : g_out_reg
            logic [Word_Width-1:0] r_data2;
            logic                  r_vld2;

            // Not gated by busy, so a read in flight when a clear starts completes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data2 <= '0;
                    r_vld2  <= 1'b0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_data2 <= r_data1;
                    end
                end
            end

            assign dataa_o = r_data2;
            assign vlda_o  = r_vld2;
        end else begin : g_no_out_reg
            assign dataa_o = r_data1;
            assign vlda_o  = r_vld1;
        end
    endgenerate

endmodule

// File: tb/tb_rf_2p_be_clr.sv
// Directed bench: three instances (latency 1 with/without forwarding, latency 2)
// share one stimulus stream; expectations are hand-computed constants.
module tb_rf_2p_be_clr;

    localparam int unsigned Depth = 16;

    logic        clk;
    logic        rst;
    logic        cena;
    logic [3:0]  addra;
    logic        cenb;
    logic [3:0]  wenb;
    logic [3:0]  addrb;
    logic [31:0] datab;
    logic        clr;

    logic [31:0] d0, dn, dr;
    logic        v0, vn, vr;
    logic        b0, bn, br;

    int n_vec  = 0;
    int n_fail = 0;

    rf_2p_be_clr #(.Word_Width(32), .Addr_Width(4), .Out_Reg(0), .Fwd_En(1)) u_fwd (
        .clk(clk), .rst(rst), .cena_i(cena), .addra_i(addra), .dataa_o(d0), .vlda_o(v0),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .datab_i(datab), .clr_i(clr),
        .busy_o(b0)
    );

    rf_2p_be_clr #(.Word_Width(32), .Addr_Width(4), .Out_Reg(0), .Fwd_En(0)) u_nofwd (
        .clk(clk), .rst(rst), .cena_i(cena), .addra_i(addra), .dataa_o(dn), .vlda_o(vn),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .datab_i(datab), .clr_i(clr),
        .busy_o(bn)
    );

    rf_2p_be_clr #(.Word_Width(32), .Addr_Width(4), .Out_Reg(1), .Fwd_En(1)) u_oreg (
        .clk(clk), .rst(rst), .cena_i(cena), .addra_i(addra), .dataa_o(dr), .vlda_o(vr),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .datab_i(datab), .clr_i(clr),
        .busy_o(br)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cena;
        logic [3:0]  addra;
        logic        cenb;
        logic [3:0]  wenb;
        logic [3:0]  addrb;
        logic [31:0] datab;
        logic [31:0] exp_d;
        logic        exp_v;
        logic [31:0] exp_nf;
    } vec_t;

    vec_t tbl [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ca, input logic [3:0] aa, input logic cb,
                         input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db,
                         input logic cl);
        cena  = ca;
        addra = aa;
        cenb  = cb;
        wenb  = wb;
        addrb = ab;
        datab = db;
        clr   = cl;
    endtask

    task automatic idle();
        drive(1'b1, 4'd0, 1'b1, 4'b1111, 4'd0, 32'h0, 1'b0);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [31:0] d);
        drive(1'b1, 4'd0, 1'b0, 4'b0000, a, d, 1'b0);
        step();
    endtask

    logic [31:0] prev_d;
    logic        prev_v;
    logic [31:0] exp_w;
    logic [31:0] pat [3];

    initial begin
        tbl[0]  = '{1'b1, 4'd0, 1'b0, 4'b0000, 4'd5, 32'h11223344, 32'h0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'd5, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h11223344, 1'b1, 32'h11223344};
        tbl[2]  = '{1'b1, 4'd0, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h11223344, 1'b0, 32'h11223344};
        tbl[3]  = '{1'b1, 4'd0, 1'b0, 4'b1010, 4'd5, 32'hAABBCCDD, 32'h11223344, 1'b0,
                    32'h11223344};
        tbl[4]  = '{1'b0, 4'd5, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h11BB33DD, 1'b1, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 4'd0, 1'b0, 4'b0000, 4'd7, 32'h0, 32'h11BB33DD, 1'b0, 32'h11BB33DD};
        tbl[6]  = '{1'b0, 4'd7, 1'b0, 4'b1100, 4'd7, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1,
                    32'h00000000};
        tbl[7]  = '{1'b0, 4'd7, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h0000FFFF, 1'b1, 32'h0000FFFF};
        tbl[8]  = '{1'b0, 4'd5, 1'b0, 4'b1111, 4'd7, 32'h12345678, 32'h11BB33DD, 1'b1,
                    32'h11BB33DD};
        tbl[9]  = '{1'b0, 4'd7, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h0000FFFF, 1'b1, 32'h0000FFFF};
        tbl[10] = '{1'b0, 4'd7, 1'b1, 4'b0000, 4'd5, 32'h0, 32'h0000FFFF, 1'b1, 32'h0000FFFF};
        tbl[11] = '{1'b0, 4'd5, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h11BB33DD, 1'b1, 32'h11BB33DD};
        tbl[12] = '{1'b0, 4'd5, 1'b0, 4'b0000, 4'd6, 32'h00000055, 32'h11BB33DD, 1'b1,
                    32'h11BB33DD};
        tbl[13] = '{1'b0, 4'd6, 1'b1, 4'b1111, 4'd0, 32'h0, 32'h00000055, 1'b1, 32'h00000055};

        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        chk32("reset dataa", d0, 32'h0);
        chk1("reset vlda", v0, 1'b0);
        chk1("reset busy", b0, 1'b0);
        chk32("reset dataa oreg", dr, 32'h0);
        chk1("reset vlda oreg", vr, 1'b0);

        // Table: latency-1 results checked on the same vector, latency-2 one vector later.
        prev_d = 32'h0;
        prev_v = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].cena, tbl[i].addra, tbl[i].cenb, tbl[i].wenb, tbl[i].addrb,
                  tbl[i].datab, 1'b0);
            step();
            chk32($sformatf("vec%0d dataa", i), d0, tbl[i].exp_d);
            chk1($sformatf("vec%0d vlda", i), v0, tbl[i].exp_v);
            chk32($sformatf("vec%0d dataa nofwd", i), dn, tbl[i].exp_nf);
            chk1($sformatf("vec%0d busy", i), b0, 1'b0);
            chk32($sformatf("vec%0d dataa oreg", i), dr, prev_d);
            chk1($sformatf("vec%0d vlda oreg", i), vr, prev_v);
            prev_d = tbl[i].exp_d;
            prev_v = tbl[i].exp_v;
        end

        // Out_Reg=1 back-to-back reads of addr 0,1,2.
        pat[0] = 32'hA0A0A0A0;
        pat[1] = 32'hB1B1B1B1;
        pat[2] = 32'hC2C2C2C2;
        for (int k = 0; k < 3; k++) write_word(4'(k), pat[k]);
        chk1("oreg quiet", vr, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b0, 4'(k), 1'b1, 4'b1111, 4'd0, 32'h0, 1'b0);
            else idle();
            step();
            chk1($sformatf("b2b%0d vlda", k), v0, k < 3);
            if (k < 3) chk32($sformatf("b2b%0d dataa", k), d0, pat[k]);
            chk1($sformatf("b2b%0d vlda oreg", k), vr, (k >= 1) && (k <= 3));
            if (k >= 1) chk32($sformatf("b2b%0d dataa oreg", k), dr, pat[(k > 3) ? 2 : k - 1]);
        end

        // Full clear: read on the clr edge is accepted, traffic during busy is dropped.
        for (int k = 0; k < Depth; k++) write_word(4'(k), 32'h5A000100 + 32'(k));
        drive(1'b0, 4'd3, 1'b1, 4'b1111, 4'd0, 32'h0, 1'b1);
        step();
        chk1("clr busy start", b0, 1'b1);
        chk1("clr edge read vlda", v0, 1'b1);
        chk32("clr edge read dataa", d0, 32'h5A000103);
        drive(1'b0, 4'd1, 1'b0, 4'b0000, 4'd2, 32'hFFFFFFFF, 1'b1);
        for (int k = 1; k <= Depth; k++) begin
            step();
            chk1($sformatf("clr%0d busy", k), b0, k < Depth);
            chk1($sformatf("clr%0d vlda", k), v0, 1'b0);
            chk32($sformatf("clr%0d dataa hold", k), d0, 32'h5A000103);
            chk1($sformatf("clr%0d vlda oreg", k), vr, k == 1);
            if (k == 1) chk32("clr inflight dataa oreg", dr, 32'h5A000103);
        end
        for (int k = 0; k < Depth; k++) begin
            drive(1'b0, 4'(k), 1'b1, 4'b1111, 4'd0, 32'h0, 1'b0);
            step();
            chk1($sformatf("cleared%0d vlda", k), v0, 1'b1);
            chk32($sformatf("cleared%0d dataa", k), d0, 32'h0);
        end

        // Reset at cycle 10 of a clear: addr 0-9 zeroed, rest untouched.
        for (int k = 0; k < Depth; k++) write_word(4'(k), 32'h5A000100 + 32'(k));
        drive(1'b1, 4'd0, 1'b1, 4'b1111, 4'd0, 32'h0, 1'b1);
        step();
        idle();
        for (int k = 0; k < 10; k++) step();
        chk1("pre-abort busy", b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("abort busy", b0, 1'b0);
        chk32("abort dataa", d0, 32'h0);
        chk1("abort vlda", v0, 1'b0);
        chk32("abort dataa oreg", dr, 32'h0);
        for (int k = 0; k < Depth; k++) begin
            drive(1'b0, 4'(k), 1'b1, 4'b1111, 4'd0, 32'h0, 1'b0);
            step();
            exp_w = (k < 10) ? 32'h0 : 32'h5A000100 + 32'(k);
            chk1($sformatf("partial%0d vlda", k), v0, 1'b1);
            chk32($sformatf("partial%0d dataa", k), d0, exp_w);
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
